// File: rtl/plot_framebuffer_vga.sv
// Plot-write frame buffer (160x120x3) scanned out as 640x480 VGA with 4x4 pixel blocks.
// Define DOUBLE_BUFFER_EN for front/back banks swapped at the start of vertical blanking.
module plot_framebuffer_vga #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] color,
  input  logic       plot,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       busy,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned NPIX  = 160 * 120;
`ifdef DOUBLE_BUFFER_EN
  localparam int unsigned BANKS = 2;
`else
  localparam int unsigned BANKS = 1;
`endif
  localparam int unsigned AW = $clog2(BANKS * NPIX);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        pix_en_q;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      pix_en_q   <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pix_en_q   <= ~pix_en_q;
      if (pix_en_q) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StClear: begin
        if (clr_addr_q == 15'(NPIX - 1)) state_d = StRun;
        else                             clr_addr_d = clr_addr_q + 15'd1;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == 10'(H_TOT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == 10'(V_TOT - 1)) ? '0 : v_cnt_q + 10'd1;
    end
  end

  assign busy = (state_q == StClear);

  // Write port: clear owns it until RUN, then in-range plots.
  logic        wr_en;
  logic [14:0] wr_addr, plot_addr, rd_addr;
  logic [2:0]  wr_data;
  logic [6:0]  rd_row;
  logic [7:0]  rd_col;
  logic        visible, hs_n, vs_n;

  assign plot_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
  assign rd_row    = v_cnt_q[8:2];
  assign rd_col    = h_cnt_q[9:2];
  assign rd_addr   = 15'({rd_row, 7'b0}) + 15'({rd_row, 5'b0}) + 15'(rd_col);
  assign visible   = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
  assign hs_n = !((h_cnt_q >= 10'(H_VIS + H_FP)) && (h_cnt_q < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs_n = !((v_cnt_q >= 10'(V_VIS + V_FP)) && (v_cnt_q < 10'(V_VIS + V_FP + V_SYNC)));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = color;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = BG_COLOR;
    end else begin
      wr_en = plot && (x < 8'd160) && (y < 7'd120);
    end
  end

  logic [AW-1:0] wr_idx, rd_idx;

`ifdef DOUBLE_BUFFER_EN
  logic front_q, pending_q, swap_ack_q, swap_fire;

  assign swap_fire = pix_en_q && pending_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'(V_VIS));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      pending_q  <= swap_fire ? swap_req : (pending_q | swap_req);
      front_q    <= front_q ^ swap_fire;
      swap_ack_q <= swap_fire;
    end
  end

  assign swap_ack = swap_ack_q;
  assign wr_idx   = AW'(wr_addr) + (front_q ? '0 : AW'(NPIX));
  assign rd_idx   = AW'(rd_addr) + (front_q ? AW'(NPIX) : '0);
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign swap_ack        = 1'b0;
  assign wr_idx          = AW'(wr_addr);
  assign rd_idx          = AW'(rd_addr);
`endif

  logic [2:0] mem [BANKS*NPIX];
  logic [2:0] rd_data_q;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en)   mem[wr_idx] <= wr_data;
    if (visible) rd_data_q   <= mem[rd_idx];
  end

  // Two pixel-clock stages so colour and sync/blank reach the pins together.
  logic       s1_vis, s1_hs, s1_vs, hs_q, vs_q, blank_q, vga_clk_q;
  logic [2:0] s1_rgb, rgb_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_rgb    <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      vga_clk_q <= ~pix_en_q;
      if (pix_en_q) begin
        s1_vis  <= visible;
        s1_hs   <= hs_n;
        s1_vs   <= vs_n;
        s1_rgb  <= visible ? rd_data_q : 3'b000;
        rgb_q   <= s1_rgb;
        hs_q    <= s1_hs;
        vs_q    <= s1_vs;
        blank_q <= s1_vis;
      end
    end
  end

  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;
endmodule

// File: tb/tb_plot_framebuffer_vga.sv
// Scoreboard bench for plot_framebuffer_vga; short vertical timing so a whole frame and wrap fit.
module tb_plot_framebuffer_vga;
  localparam int HT = 800;
  localparam int VV = 32, VFP = 1, VSY = 2, VBP = 1;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int NPIX = 19200;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] color = '0;
  logic       plot = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack, busy, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  always #10 CLOCK_50 = ~CLOCK_50;

  plot_framebuffer_vga #(
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .x(x), .y(y), .color(color), .plot(plot),
    .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  typedef struct {
    int rgb;   // -1: memory content never written, colour not checked
    bit hs;
    bit vs;
    bit blank_n;
  } exp_t;

  exp_t exp_q[$];
  int   fb[NPIX];
  int   edge_n;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s at edge %0d: got %h want %h", name, edge_n, got, want);
    end
  endtask

  // Reference: pixel index C's colour comes from the buffer as it stood before edge 2C+1.
  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      edge_n = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (edge_n % 2 == 1) begin
        int c, h, v;
        exp_t e;
        c = (edge_n - 1) / 2;
        h = c % HT;
        v = (c / HT) % VT;
        e.blank_n = (h < 640) && (v < VV);
        e.hs      = !(h >= 656 && h < 752);
        e.vs      = !(v >= VV + VFP && v < VV + VFP + VSY);
        e.rgb     = e.blank_n ? fb[(v / 4) * 160 + (h / 4)] : 0;
        exp_q.push_back(e);
      end
      if (edge_n <= NPIX) fb[edge_n - 1] = 0;
      else if (plot && int'(x) < 160 && int'(y) < 120) fb[int'(y) * 160 + int'(x)] = int'(color);
    end
  end

  always @(negedge CLOCK_50) begin
    if (resetn) begin
      check("busy", 32'(busy), 32'(edge_n < NPIX));
      check("vga_clk", 32'(VGA_CLK), 32'(edge_n % 2));
      check("sync_n", 32'(VGA_SYNC_N), 32'd0);
      check("swap_ack", 32'(swap_ack), 32'd0);
      if (edge_n >= 4 && edge_n % 2 == 0) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hs", 32'(VGA_HS), 32'(e.hs));
          check("vs", 32'(VGA_VS), 32'(e.vs));
          check("blank_n", 32'(VGA_BLANK_N), 32'(e.blank_n));
          if (e.rgb >= 0) begin
            logic [2:0] c3;
            c3 = 3'(e.rgb);
            check("rgb", {8'h00, VGA_R, VGA_G, VGA_B},
                  {8'h00, {8{c3[2]}}, {8{c3[1]}}, {8{c3[0]}}});
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_hs", 32'(VGA_HS), 32'd1);
    check("rst_vs", 32'(VGA_VS), 32'd1);
    check("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    check("rst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("rst_vga_clk", 32'(VGA_CLK), 32'd0);
    check("rst_swap_ack", 32'(swap_ack), 32'd0);
  endtask

  task automatic rand_plot(input int y_max);
    x     = 8'($urandom_range(0, 170));
    y     = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(120, 127))
                                          : 7'($urandom_range(0, y_max));
    color = 3'($urandom);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) fb[i] = -1;
    repeat (3) @(negedge CLOCK_50);
    check_reset_state();

    // Plot held high through a clear that is cut short by reset.
    plot   = 1'b1;
    resetn = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLOCK_50);
      rand_plot(9);
    end
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_state();
    resetn = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge CLOCK_50);
      rand_plot(9);
    end

    // Directed boundary writes right after the clear, then sparse random traffic.
    x = 8'd10;  y = 7'd5;   color = 3'b100; @(negedge CLOCK_50);
    x = 8'd160; y = 7'd5;   color = 3'b111; @(negedge CLOCK_50);
    x = 8'd0;   y = 7'd120; color = 3'b111; @(negedge CLOCK_50);
    x = 8'd159; y = 7'd7;   color = 3'b011; @(negedge CLOCK_50);
    x = 8'd0;   y = 7'd0;   color = 3'b010; @(negedge CLOCK_50);
    for (int i = 0; i < 46800; i++) begin
      plot = ($urandom_range(0, 40) == 0);
      rand_plot(9);
      @(negedge CLOCK_50);
    end
    plot = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
